mdu_ctrl: RTL and testbench

Iterative multiply/divide controller for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a one-bit-per-cycle shift-add multiply or restoring divide. It owns the architectural HI/LO registers and raises a stall request while an operation is in flight and the pipeline tries to touch HI/LO or issue another MDU op.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mdu_iter_core.sv | 54 +++++
 rtl/mdu_ctrl.sv | 158 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: MDU op encodings, MDU FSM states and helpers.
package mips_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } mdu_state_t;

    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on a
// 2*WIDTH-bit shift register holding {hi, lo} / {remainder, quotient}.
module mdu_iter_core
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_part;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_mul;
    logic [2*WIDTH-1:0] w_acc_div;

    // Multiply: add multiplicand into the upper half when lsb set, then shift right.
    assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m & {WIDTH{r_acc[0]}}};
    assign w_acc_mul = {w_add, r_acc[WIDTH-1:1]};

    // Divide: trial-subtract divisor from the shifted partial remainder; borrow means restore.
    assign w_part    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_part - {1'b0, r_m};
    assign w_acc_div = w_diff[WIDTH] ? {w_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_m      <= i_is_div ? i_b : i_a;
            r_acc    <= {WIDTH'(0), (i_is_div ? i_a : i_b)};
        end else if (i_step) begin
            r_acc    <= r_is_div ? w_acc_div : w_acc_mul;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller: FSM, sign handling, HI/LO
// ownership, divide-by-zero flag and pipeline stall request.
module mdu_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_rd_hilo,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_stall_req,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_t r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_div0, w_div0_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;

    logic               w_load;
    logic               w_step;
    logic               w_op_signed;
    logic               w_op_div;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op_signed = mdu_is_signed(i_op);
    assign w_op_div    = mdu_is_div(i_op);
    assign w_a_abs     = (w_op_signed & i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_abs     = (w_op_signed & i_b[WIDTH-1]) ? -i_b : i_b;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (w_op_div),
        .i_a      (w_a_abs),
        .i_b      (w_b_abs),
        .o_acc    (w_acc)
    );

    // Magnitude result back to signed: quotient/product by sign xor, remainder by dividend sign.
    assign w_prod   = r_neg_q ? -w_acc : w_acc;
    assign w_quo    = w_acc[WIDTH-1:0];
    assign w_rem    = w_acc[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_neg_q ? -w_quo : w_quo) : w_prod[WIDTH-1:0];
    assign w_res_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_div0_nxt   = r_div0;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_is_div_nxt = r_is_div;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt  = CALC;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_load       = 1'b1;
                    w_is_div_nxt = w_op_div;
                    w_div0_nxt   = w_op_div & (i_b == '0);
                    w_neg_q_nxt  = w_op_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    w_neg_r_nxt  = w_op_signed & w_op_div & i_a[WIDTH-1];
                end else begin
                    if (i_mthi) w_hi_nxt = i_wdata;
                    if (i_mtlo) w_lo_nxt = i_wdata;
                end
            end
            CALC: begin
                w_step    = 1'b1;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) w_state_nxt = SIGN;
            end
            SIGN: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_hi_nxt    = w_res_hi;
                w_lo_nxt    = w_res_lo;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_div0   <= w_div0_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
        end
    end

    // Pipeline may not touch HI/LO or issue another MDU op while one is in flight.
    assign o_stall_req = r_busy & (i_start | i_rd_hilo | i_mthi | i_mtlo);
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_div0      = r_div0;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed + scoreboard bench for mdu_ctrl: expected HI/LO/div0 queued at issue,
// checked when done pulses; latency, stall and reset behaviour checked inline.
module tb_mdu_ctrl;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_rd_hilo, i_mthi, i_mtlo;
    logic [1:0]  i_op;
    logic [31:0] i_a, i_b, i_wdata;
    logic        o_busy, o_stall_req, o_done, o_div0;
    logic [31:0] o_hi, o_lo;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mdu_ctrl #(.WIDTH(32)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_rd_hilo   (i_rd_hilo),
        .i_mthi      (i_mthi),
        .i_mtlo      (i_mtlo),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_stall_req (o_stall_req),
        .o_done      (o_done),
        .o_div0      (o_div0),
        .o_hi        (o_hi),
        .o_lo        (o_lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference results from wide native arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa     = longint'($signed(a));
        sbv    = longint'($signed(b));
        e.div0 = 1'b0;
        case (op)
            MDU_MULT: begin
                p = sa * sbv;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    e.div0 = 1'b1; e.hi = a; e.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    q = sa / sbv; r = sa % sbv;
                    e.hi = 32'(r); e.lo = 32'(q);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.div0 = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (o_done) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_done observed=done expected=no_done");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_hi", 64'(o_hi), 64'(e.hi));
                chk("sb_lo", 64'(o_lo), 64'(e.lo));
                chk("sb_div0", 64'(o_div0), 64'(e.div0));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_op = op; i_a = a; i_b = b; i_start = 1'b1;
        sb.push_back(model(op, a, b));
    endtask

    // Advance from cycle k0 until done; lat is the cycle number of done (0 on timeout).
    task automatic wait_done(input int k0, output int lat, output int bc);
        lat = 0; bc = 0;
        for (int k = k0; k < k0 + 60; k++) begin
            cyc();
            i_start = 1'b0;
            @(negedge clk);
            if (o_done) begin
                lat = k;
                break;
            end
            if (o_busy) bc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat, bc;
        cyc();
        issue(op, a, b);
        wait_done(1, lat, bc);
        chk({tag, "_latency"}, 64'(lat), 64'd34);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
        cyc();
        @(negedge clk);
        chk({tag, "_done_fall"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int          lat, bc, cnt_pre, cnt_stall, lo_moved;
        exp_t        e1, e2;

        i_reset = 1'b1; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
        i_rd_hilo = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0; i_wdata = '0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_div0", 64'(o_div0), 64'd0);
        chk("rst_hi", 64'(o_hi), 64'd0);
        chk("rst_lo", 64'(o_lo), 64'd0);
        cyc();
        i_reset = 1'b0;

        // MTHI in idle writes hi only; then MTLO writes lo only.
        cyc();
        i_mthi = 1'b1; i_wdata = 32'h1234;
        @(negedge clk);
        chk("mthi_no_stall", 64'(o_stall_req), 64'd0);
        cyc();
        i_mthi = 1'b0; i_mtlo = 1'b1; i_wdata = 32'hABCD;
        @(negedge clk);
        chk("mthi_hi", 64'(o_hi), 64'h1234);
        chk("mthi_lo_kept", 64'(o_lo), 64'd0);
        cyc();
        i_mtlo = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", 64'(o_lo), 64'hABCD);
        chk("mtlo_hi_kept", 64'(o_hi), 64'h1234);

        run_op("mult_m3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by0", MDU_DIVU, 32'h1234, 32'd0);
        cyc(); cyc();
        @(negedge clk);
        chk("div0_sticky", 64'(o_div0), 64'd1);
        run_op("div_neg_by0", MDU_DIV, 32'hFFFF_FFF0, 32'd0);
        run_op("multu_clr_div0", MDU_MULTU, 32'd2, 32'd3);

        // MULTU with MFHI/MFLO held from cycle 5; back-to-back issue in the done cycle.
        e1 = model(MDU_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        e2 = model(MDU_MULTU, 32'h1357_9BDF, 32'h2468_ACE0);
        cyc();
        issue(MDU_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        cnt_pre = 0; cnt_stall = 0;
        for (int k = 1; k <= 33; k++) begin
            cyc();
            i_start   = 1'b0;
            i_rd_hilo = (k >= 5);
            @(negedge clk);
            if (k >= 5) cnt_stall += int'(o_stall_req);
            else        cnt_pre   += int'(o_stall_req);
        end
        chk("rd_stall_pre", 64'(cnt_pre), 64'd0);
        chk("rd_stall_cycles", 64'(cnt_stall), 64'd29);
        cyc();
        issue(MDU_MULTU, 32'h1357_9BDF, 32'h2468_ACE0);
        @(negedge clk);
        chk("rd_release_stall", 64'(o_stall_req), 64'd0);
        chk("rd_release_done", 64'(o_done), 64'd1);
        chk("rd_release_hi", 64'(o_hi), 64'(e1.hi));
        chk("rd_release_lo", 64'(o_lo), 64'(e1.lo));
        cyc();
        i_start = 1'b0; i_rd_hilo = 1'b0; i_mtlo = 1'b1; i_wdata = 32'hDEAD;
        @(negedge clk);
        chk("b2b_busy", 64'(o_busy), 64'd1);
        chk("mtlo_busy_stall", 64'(o_stall_req), 64'd1);
        lo_moved = 0;
        for (int k = 36; k <= 50; k++) begin
            cyc();
            @(negedge clk);
            if (o_lo !== e1.lo) lo_moved++;
        end
        chk("mtlo_busy_lo_held", 64'(lo_moved), 64'd0);
        wait_done(51, lat, bc);
        chk("b2b_latency", 64'(lat), 64'd68);
        chk("mtlo_done_no_stall", 64'(o_stall_req), 64'd0);
        cyc();
        i_mtlo = 1'b0;
        @(negedge clk);
        chk("mtlo_reissued_lo", 64'(o_lo), 64'hDEAD);
        chk("mtlo_reissued_hi", 64'(o_hi), 64'(e2.hi));

        // Reset in cycle 10 of a MULT issued after MTHI 0x55: result discarded.
        cyc();
        i_mthi = 1'b1; i_wdata = 32'h55;
        cyc();
        i_mthi = 1'b0;
        i_op = MDU_MULT; i_a = 32'd5; i_b = 32'd6; i_start = 1'b1;
        @(negedge clk);
        chk("pre_rst_hi", 64'(o_hi), 64'h55);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            i_start = 1'b0;
            i_reset = (k == 10);
        end
        cyc();
        i_reset = 1'b0;
        issue(MDU_MULTU, 32'd9, 32'd9);
        @(negedge clk);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_done", 64'(o_done), 64'd0);
        chk("midrst_hi", 64'(o_hi), 64'd0);
        chk("midrst_lo", 64'(o_lo), 64'd0);
        cyc();
        i_start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(o_busy), 64'd1);
        wait_done(13, lat, bc);
        chk("post_rst_latency", 64'(lat), 64'd45);

        for (int i = 0; i < 6; i++) begin
            run_op("rnd", 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        cyc(); cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
